// File: rtl/wb_master_pkg.sv
// wb_master_pkg: FSM state type, Wishbone CTI codes and shared defaults for wb_burst_master
package wb_master_pkg;
    typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam int TMO_CYC_DEF = 1023;
    // Cycle type for the beat about to be presented, given the beats still to be acked
    function automatic logic [2:0] cti_of(input logic single, input logic [8:0] left);
        return single ? CTI_CLASSIC : (left == 9'd1 ? CTI_EOB : CTI_INCR);
    endfunction
endpackage

// File: rtl/wb_ack_watchdog.sv
// wb_ack_watchdog: counts strobe cycles without an ack and flags a timeout
//   clk_i, rst_ni : clock, async active-low reset
//   stb_i, ack_i  : bus strobe and raw slave ack
//   tmo_o         : high in the TMO_CYC-th consecutive unacked strobe cycle
module wb_ack_watchdog #(
    parameter int TMO_CYC = 1023
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic stb_i,
    input  logic ack_i,
    output logic tmo_o
);
    logic [9:0] cnt_q;
    assign tmo_o = stb_i && !ack_i && cnt_q == 10'(TMO_CYC - 1);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= (stb_i && !ack_i && !tmo_o) ? cnt_q + 10'd1 : '0;
    end
endmodule

// File: rtl/wb_burst_master.sv
// wb_burst_master: command-driven Wishbone incrementing-burst master with ack watchdog
//   sys_clk, resetn                   : clock, async active-low reset
//   cmd_valid/ready, cmd_we/addr/len  : burst command (len = beats - 1)
//   wr_valid/ready, wr_data/sel       : write-data stream, one-entry holding register
//   rd_valid, rd_data                 : read beats, no backpressure
//   busy, done, err                   : status; done/err are one-cycle pulses
//   wb_*                              : Wishbone master port
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int APP_AW  = 26,
    parameter int DW      = 32,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DW-1:0]     wr_data,
    input  logic [DW/8-1:0]   wr_sel,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);
    localparam int SW = DW / 8;
    localparam logic [APP_AW-1:0] STEP = APP_AW'(SW);

    state_t            state_q;
    logic              run_q, busy_q, cyc_q, stb_q, we_q, single_q, done_q, err_q, rd_valid_q;
    logic [APP_AW-1:0] addr_q;
    logic [8:0]        cnt_q, ld_q;
    logic [2:0]        cti_q;
    logic [DW-1:0]     dat_q, rd_data_q;
    logic [SW-1:0]     sel_q;
    logic              ack, last, tmo, wr_fire;
    logic [8:0]        beats;

    assign beats     = {1'b0, cmd_len} + 9'd1;
    // acks outside a strobe are not ours
    assign ack       = wb_ack_i && stb_q;
    assign last      = cnt_q == 9'd1;
    // run_q keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = run_q && state_q == IDLE;
    assign wr_ready  = state_q == WR && ld_q != 9'd0 && (!stb_q || ack);
    assign wr_fire   = wr_valid && wr_ready;

    wb_ack_watchdog #(.TMO_CYC(TMO_CYC)) u_wdog (
        .clk_i (sys_clk),
        .rst_ni(resetn),
        .stb_i (stb_q),
        .ack_i (wb_ack_i),
        .tmo_o (tmo)
    );

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            single_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            ld_q       <= '0;
            cti_q      <= CTI_CLASSIC;
            dat_q      <= '0;
            rd_data_q  <= '0;
            sel_q      <= '0;
        end else begin
            run_q      <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid && cmd_ready) begin
                    state_q  <= cmd_we ? WR : RD;
                    busy_q   <= 1'b1;
                    cyc_q    <= 1'b1;
                    stb_q    <= !cmd_we;
                    we_q     <= cmd_we;
                    single_q <= cmd_len == 8'd0;
                    addr_q   <= cmd_addr & ~APP_AW'(SW - 1);
                    cnt_q    <= beats;
                    ld_q     <= cmd_we ? beats : 9'd0;
                    cti_q    <= cti_of(cmd_len == 8'd0, beats);
                    sel_q    <= cmd_we ? '0 : '1;
                end
                WR, RD: begin
                    if (ack) begin
                        addr_q     <= addr_q + STEP;
                        cnt_q      <= cnt_q - 9'd1;
                        cti_q      <= cti_of(single_q, cnt_q - 9'd1);
                        rd_valid_q <= !we_q;
                        if (!we_q) rd_data_q <= wb_dat_i;
                    end
                    if (wr_fire) begin
                        dat_q <= wr_data;
                        sel_q <= wr_sel;
                        ld_q  <= ld_q - 9'd1;
                    end
                    // timeout drops the strobe, which also discards any held write beat
                    if (tmo || (ack && last)) begin
                        state_q <= FIN;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= tmo;
                    end else if (we_q) begin
                        stb_q <= wr_fire || (stb_q && !ack);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_addr_o = addr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_cti_o  = cti_q;
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: directed bench with a Wishbone slave model and scoreboards for beats, read data and done/err
module tb_wb_burst_master;
    localparam int AW = 26;
    localparam int DW = 32;

    logic          sys_clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    wr_sel = '0;
    logic          cmd_ready, wr_ready, rd_valid, busy, done, err;
    logic [DW-1:0] rd_data;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic          wb_ack_i = 1'b0;
    logic [DW-1:0] wb_dat_i = '0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
        logic [3:0]    sel;
        logic [2:0]    cti;
    } beat_t;

    beat_t         exp_beats[$];
    logic [DW-1:0] exp_rd[$];
    logic          exp_done[$];
    logic [DW-1:0] mem[int];
    int checks = 0, fails = 0;
    int dly = 0, wcnt = 0, beats_seen = 0, stb_cycles = 0;
    bit noack = 1'b0;

    wb_burst_master #(.APP_AW(AW), .DW(DW), .TMO_CYC(16)) dut (
        .sys_clk(sys_clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_sel(wr_sel),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name, input logic [63:0] act);
        checks++;
        fails++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic push_beat(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                             input logic [3:0] s, input logic [2:0] c);
        beat_t b;
        b.addr = a; b.we = we; b.data = d; b.sel = s; b.cti = c;
        exp_beats.push_back(b);
    endtask

    // Monitor for one acked beat: compare against the scoreboard and serve the slave memory
    task automatic take_beat();
        beat_t e;
        logic [DW-1:0] w;
        int a;
        a = int'(wb_addr_o);
        if (exp_beats.size() == 0) miss("beat_extra", 64'(wb_addr_o));
        else begin
            e = exp_beats.pop_front();
            chk("beat_addr", 64'(wb_addr_o), 64'(e.addr));
            chk("beat_we", 64'(wb_we_o), 64'(e.we));
            chk("beat_cti", 64'(wb_cti_o), 64'(e.cti));
            chk("beat_sel", 64'(wb_sel_o), 64'(e.sel));
            if (e.we) chk("beat_wdata", 64'(wb_dat_o), 64'(e.data));
        end
        if (wb_we_o) begin
            w = mem.exists(a) ? mem[a] : '0;
            for (int b = 0; b < 4; b++) if (wb_sel_o[b]) w[8*b +: 8] = wb_dat_o[8*b +: 8];
            mem[a] = w;
        end else begin
            wb_dat_i = mem.exists(a) ? mem[a] : ~DW'(a);
        end
    endtask

    // Slave model: acks after dly wait cycles of strobe, or never when noack is set
    always @(negedge sys_clk) begin
        if (resetn && wb_cyc_o && wb_stb_o) begin
            stb_cycles++;
            if (!noack && wcnt >= dly) begin
                wb_ack_i = 1'b1;
                wcnt = 0;
                beats_seen++;
                take_beat();
            end else begin
                wb_ack_i = 1'b0;
                wcnt++;
            end
        end else begin
            wb_ack_i = 1'b0;
            wcnt = 0;
        end
    end

    always @(negedge sys_clk) begin
        if (rd_valid) begin
            if (exp_rd.size() == 0) miss("rd_extra", 64'(rd_data));
            else chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
        end
        if (done) begin
            if (exp_done.size() == 0) miss("done_extra", 64'(err));
            else chk("done_err", 64'(err), 64'(exp_done.pop_front()));
        end else if (err) miss("err_without_done", 64'(err));
    end

    task automatic step();
        @(negedge sys_clk);
        #2;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [7:0] len);
        int n = 0;
        while (!cmd_ready && n < 200) begin step(); n++; end
        if (n == 200) miss("cmd_ready_timeout", 64'(cmd_ready));
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [3:0] s);
        int n = 0;
        wr_valid = 1'b1; wr_data = d; wr_sel = s;
        while (!wr_ready && n < 200) begin step(); n++; end
        if (n == 200) miss("wr_ready_timeout", 64'(wr_ready));
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin step(); n++; end
        if (n == 500) miss("busy_timeout", 64'(busy));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        step(); step();
        chk("rst_cmd_ready", 64'(cmd_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_cyc", 64'(wb_cyc_o), 0);
        chk("rst_stb", 64'(wb_stb_o), 0);
        chk("rst_done_err_rdv", 64'({done, err, rd_valid}), 0);
        chk("rst_addr_cti", 64'({wb_addr_o, wb_cti_o}), 0);
        resetn = 1'b1;
        step();
        chk("cmd_ready_after_reset", 64'(cmd_ready), 1);

        // single write, slave waits 3 cycles
        dly = 3;
        push_beat(26'h40, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000);
        exp_done.push_back(1'b0);
        issue(1'b1, 26'h40, 8'd0);
        chk("busy_in_burst", 64'(busy), 1);
        send(32'hDEADBEEF, 4'hF);
        wr_valid = 1'b0;
        wait_idle();

        // 8-beat write then read back
        dly = 1;
        for (int i = 0; i < 8; i++)
            push_beat(26'h1000 + 26'(4 * i), 1'b1, 32'h01010101 * i, 4'hF, i == 7 ? 3'b111 : 3'b010);
        exp_done.push_back(1'b0);
        issue(1'b1, 26'h1000, 8'd7);
        for (int i = 0; i < 8; i++) send(32'h01010101 * i, 4'hF);
        wr_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 8; i++) begin
            push_beat(26'h1000 + 26'(4 * i), 1'b0, '0, 4'hF, i == 7 ? 3'b111 : 3'b010);
            exp_rd.push_back(32'h01010101 * i);
        end
        exp_done.push_back(1'b0);
        issue(1'b0, 26'h1000, 8'd7);
        wait_idle();

        // write-data starvation for 5 cycles mid-burst
        dly = 0;
        for (int i = 0; i < 6; i++)
            push_beat(26'h2000 + 26'(4 * i), 1'b1, 32'hC0DE0000 + i, 4'hF, i == 5 ? 3'b111 : 3'b010);
        exp_done.push_back(1'b0);
        issue(1'b1, 26'h2000, 8'd5);
        for (int i = 0; i < 3; i++) send(32'hC0DE0000 + i, 4'hF);
        wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("gap_stb_low", 64'(wb_stb_o), 0);
            chk("gap_cyc_high", 64'(wb_cyc_o), 1);
        end
        for (int i = 3; i < 6; i++) send(32'hC0DE0000 + i, 4'hF);
        wr_valid = 1'b0;
        wait_idle();

        // address wrap at the top of the byte space
        push_beat(26'h3FFFFFC, 1'b1, 32'h11111111, 4'hF, 3'b010);
        push_beat(26'h0000000, 1'b1, 32'h22222222, 4'h3, 3'b111);
        exp_done.push_back(1'b0);
        issue(1'b1, 26'h3FFFFFC, 8'd1);
        send(32'h11111111, 4'hF);
        send(32'h22222222, 4'h3);
        wr_valid = 1'b0;
        wait_idle();

        // timeout: slave never acks a 4-beat read
        noack = 1'b1;
        stb_cycles = 0;
        exp_done.push_back(1'b1);
        issue(1'b0, 26'h3000, 8'd3);
        wait_idle();
        chk("tmo_stb_cycles", 64'(stb_cycles), 16);
        chk("tmo_cyc_low", 64'(wb_cyc_o), 0);
        chk("tmo_cmd_ready", 64'(cmd_ready), 1);
        noack = 1'b0;

        // reset during beat 3 of an 8-beat read
        dly = 1;
        for (int i = 0; i < 8; i++) begin
            push_beat(26'h1000 + 26'(4 * i), 1'b0, '0, 4'hF, i == 7 ? 3'b111 : 3'b010);
            exp_rd.push_back(32'h01010101 * i);
        end
        beats_seen = 0;
        issue(1'b0, 26'h1000, 8'd7);
        for (int n = 0; n < 100 && beats_seen < 3; n++) step();
        chk("mid_beats_seen", 64'(beats_seen), 3);
        step();
        resetn = 1'b0;
        #1;
        chk("mid_rst_cyc", 64'(wb_cyc_o), 0);
        chk("mid_rst_stb", 64'(wb_stb_o), 0);
        chk("mid_rst_busy_ready", 64'({busy, cmd_ready}), 0);
        exp_beats.delete();
        exp_rd.delete();
        step(); step(); step();
        resetn = 1'b1;
        step();
        chk("mid_ready_after_release", 64'(cmd_ready), 1);
        dly = 0;
        push_beat(26'h1004, 1'b0, '0, 4'hF, 3'b000);
        exp_rd.push_back(32'h01010101);
        exp_done.push_back(1'b0);
        issue(1'b0, 26'h1004, 8'd0);
        wait_idle();

        step(); step();
        chk("beats_left", 64'(exp_beats.size()), 0);
        chk("rd_left", 64'(exp_rd.size()), 0);
        chk("done_left", 64'(exp_done.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
